// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic scan scheduler.
// Defaults assume a 50 MHz clock.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRE      = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        SETTLE    = 3'd4,
        GUARD     = 3'd5
    } scan_state_e;

    localparam int DEF_N_SENSORS      = 3;
    localparam int DEF_DIST_W         = 8;
    localparam int DEF_ENABLE_CYCLES  = 100;
    localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_GUARD_CYCLES   = 500_000;
    localparam int DEF_NEAR_THRESH    = 20;

    // Wide enough for any supported distance width; users slice the low bits.
    localparam logic [63:0] DIST_TIMEOUT = {64{1'b1}};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchroniser for a vector of asynchronous echo pins, with
// registered single-cycle rise and fall pulses taken on the synchronised value.
module echo_sync_edge #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain plus edge detection against the previous synced value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
            rise   <= {WIDTH{1'b0}};
            fall   <= {WIDTH{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise   <= sync_r & ~prev_r;
            fall   <= ~sync_r & prev_r;
        end
    end

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler firing one ultrasonic sensor at a time, latching its
// distance on echo end (or all-ones on timeout) with a ring-down guard between shots.
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int N_SENSORS      = DEF_N_SENSORS,
    parameter int DIST_W         = DEF_DIST_W,
    parameter int ENABLE_CYCLES  = DEF_ENABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int NEAR_THRESH    = DEF_NEAR_THRESH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [N_SENSORS-1:0]          echo,
    input  logic [N_SENSORS*DIST_W-1:0]   distance_in,
    output logic [N_SENSORS-1:0]          enable,
    output logic [N_SENSORS*DIST_W-1:0]   dist_out,
    output logic [N_SENSORS-1:0]          dist_valid,
    output logic [N_SENSORS-1:0]          near,
    output logic [N_SENSORS-1:0]          timeout,
    output logic [$clog2(N_SENSORS)-1:0]  sel,
    output logic                          busy
);

    localparam int SEL_W   = $clog2(N_SENSORS);
    localparam int BASE_W  = $clog2(N_SENSORS * DIST_W);
    localparam int CNT_MAX = max2(max2(ENABLE_CYCLES, TIMEOUT_CYCLES),
                                  max2(SETTLE_CYCLES, GUARD_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     ENABLE_LAST  = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [SEL_W-1:0]     SEL_LAST     = SEL_W'(N_SENSORS - 1);
    localparam logic [N_SENSORS-1:0] ONE_HOT0     = {{(N_SENSORS-1){1'b0}}, 1'b1};
    localparam logic [DIST_W-1:0]    DIST_ALL_ONES = DIST_TIMEOUT[DIST_W-1:0];
    // One extra bit so a threshold of 2**DIST_W still compares correctly.
    localparam logic [DIST_W:0]      NEAR_LIM     = (DIST_W+1)'(NEAR_THRESH);

    scan_state_e          state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [SEL_W-1:0]     sel_next_s;
    logic [BASE_W-1:0]    base_s;
    logic [DIST_W-1:0]    dist_sel_s;
    logic [N_SENSORS-1:0] echo_rise_s;
    logic [N_SENSORS-1:0] echo_fall_s;

    echo_sync_edge #(
        .WIDTH (N_SENSORS)
    ) u_echo_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (echo),
        .rise (echo_rise_s),
        .fall (echo_fall_s)
    );

    // Saturating counter increment, next sensor index and selected distance slice.
    always_comb begin
        cnt_inc_s  = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_W'(1);
        sel_next_s = (sel == SEL_LAST) ? {SEL_W{1'b0}} : sel + SEL_W'(1);
        base_s     = BASE_W'(sel) * BASE_W'(DIST_W);
        dist_sel_s = distance_in[base_s +: DIST_W];
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            sel        <= {SEL_W{1'b0}};
            enable     <= {N_SENSORS{1'b0}};
            dist_out   <= {(N_SENSORS*DIST_W){1'b1}};
            dist_valid <= {N_SENSORS{1'b0}};
            near       <= {N_SENSORS{1'b0}};
            timeout    <= {N_SENSORS{1'b0}};
            busy       <= 1'b0;
        end else begin
            dist_valid <= {N_SENSORS{1'b0}};
            case (state_r)
                IDLE: begin
                    if (run) begin
                        state_r <= FIRE;
                        enable  <= ONE_HOT0 << sel;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b1;
                    end
                end
                FIRE: begin
                    if (cnt_r == ENABLE_LAST) begin
                        enable  <= {N_SENSORS{1'b0}};
                        state_r <= WAIT_RISE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                // The timeout budget spans both echo-wait states.
                WAIT_RISE, WAIT_FALL: begin
                    if (cnt_r == TIMEOUT_LAST) begin
                        dist_out[base_s +: DIST_W] <= DIST_ALL_ONES;
                        timeout[sel]               <= 1'b1;
                        near[sel]                  <= 1'b0;
                        dist_valid                 <= ONE_HOT0 << sel;
                        state_r                    <= GUARD;
                        cnt_r                      <= {CNT_W{1'b0}};
                    end else if (state_r == WAIT_RISE && echo_rise_s[sel]) begin
                        state_r <= WAIT_FALL;
                        cnt_r   <= cnt_inc_s;
                    end else if (state_r == WAIT_FALL && echo_fall_s[sel]) begin
                        state_r <= SETTLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        dist_out[base_s +: DIST_W] <= dist_sel_s;
                        timeout[sel]               <= 1'b0;
                        near[sel]                  <= ({1'b0, dist_sel_s} < NEAR_LIM);
                        dist_valid                 <= ONE_HOT0 << sel;
                        state_r                    <= GUARD;
                        cnt_r                      <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                GUARD: begin
                    if (cnt_r == GUARD_LAST) begin
                        sel   <= sel_next_s;
                        cnt_r <= {CNT_W{1'b0}};
                        if (run) begin
                            state_r <= FIRE;
                            enable  <= ONE_HOT0 << sel_next_s;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    enable  <= {N_SENSORS{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed bench for ultrasonic_scan_scheduler with a behavioural sensor model
// that answers each enable pulse with a delayed echo pulse.
module tb_ultrasonic_scan_scheduler;

    localparam int N          = 3;
    localparam int DW         = 8;
    localparam int ECHO_DELAY = 30;
    localparam int ECHO_LEN   = 50;
    localparam int WAIT_LIMIT = 2000;

    logic          clk;
    logic          rst;
    logic          run;
    logic [N-1:0]  echo;
    logic [N*DW-1:0] distance_in;
    logic [N-1:0]  enable;
    logic [N*DW-1:0] dist_out;
    logic [N-1:0]  dist_valid;
    logic [N-1:0]  near;
    logic [N-1:0]  timeout;
    logic [1:0]    sel;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Sensor model state: mode 0 = normal echo, 1 = silent, 2 = stuck high.
    int           mode [N];
    int           ecnt [N];
    bit           noise_en;
    logic [N-1:0] prev_en;
    logic [N-1:0] active;

    ultrasonic_scan_scheduler #(
        .N_SENSORS      (3),
        .DIST_W         (8),
        .ENABLE_CYCLES  (5),
        .TIMEOUT_CYCLES (200),
        .SETTLE_CYCLES  (4),
        .GUARD_CYCLES   (20),
        .NEAR_THRESH    (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .echo        (echo),
        .distance_in (distance_in),
        .enable      (enable),
        .dist_out    (dist_out),
        .dist_valid  (dist_valid),
        .near        (near),
        .timeout     (timeout),
        .sel         (sel),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Echo ECHO_LEN cycles long starting ECHO_DELAY cycles after enable falls;
    // sensors not currently owning the path may emit random noise.
    initial begin
        echo     = '0;
        prev_en  = '0;
        active   = '0;
        noise_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            mode[i] = 0;
            ecnt[i] = 100000;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (enable[i] && !prev_en[i]) begin
                    active    = '0;
                    active[i] = 1'b1;
                end
                if (prev_en[i] && !enable[i]) ecnt[i] = 0;
                else if (ecnt[i] < 100000) ecnt[i]++;
                if (mode[i] == 2)      echo[i] = 1'b1;
                else if (mode[i] == 1) echo[i] = 1'b0;
                else if (active[i])    echo[i] = (ecnt[i] >= ECHO_DELAY) && (ecnt[i] < ECHO_DELAY + ECHO_LEN);
                else                   echo[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            prev_en = enable;
        end
    end

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(enable) && $onehot0(dist_valid)) else begin
            errors++;
            $display("FAIL onehot: enable=%b dist_valid=%b, required at most one bit each", enable, dist_valid);
        end
    end

    function automatic bit cond_met(input int which);
        case (which)
            0:       return enable !== '0;
            1:       return enable === '0;
            2:       return dist_valid !== '0;
            default: return busy === 1'b0;
        endcase
    endfunction

    // which: 0 enable on, 1 enable off, 2 dist_valid, 3 idle. n = cycles waited.
    task automatic wait_for(input int which, output int n);
        n = 0;
        while (!cond_met(which)) begin
            if (n >= WAIT_LIMIT) begin
                checks++;
                errors++;
                $display("FAIL wait_%0d: still waiting after %0d cycles, required within %0d", which, n, WAIT_LIMIT);
                n = -1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (enable !== 3'b000) begin errors++; $display("FAIL rst_enable: got %b expected 000", enable); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", sel); end
        checks++; if (dist_out !== 24'hFFFFFF) begin errors++; $display("FAIL rst_dist: got %h expected ffffff", dist_out); end
        checks++; if (dist_valid !== 3'b000) begin errors++; $display("FAIL rst_valid: got %b expected 000", dist_valid); end
        checks++; if (near !== 3'b000) begin errors++; $display("FAIL rst_near: got %b expected 000", near); end
        checks++; if (timeout !== 3'b000) begin errors++; $display("FAIL rst_timeout: got %b expected 000", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_run: busy got %b expected 0", busy); end
    endtask

    task automatic test_normal_scan();
        int n;
        logic [2:0] exp_oh;
        logic [7:0] got_d;
        logic [7:0] exp_d [3];
        exp_d = '{8'd90, 8'd15, 8'd40};
        distance_in = {8'd40, 8'd15, 8'd90};
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_oh = 3'b001 << k;
            wait_for(0, n);
            checks++; if (enable !== exp_oh) begin errors++; $display("FAIL scan_enable%0d: got %b expected %b", k, enable, exp_oh); end
            wait_for(2, n);
            checks++; if (dist_valid !== exp_oh) begin errors++; $display("FAIL scan_valid%0d: got %b expected %b", k, dist_valid, exp_oh); end
            got_d = 8'(dist_out >> (8 * k));
            checks++; if (got_d !== exp_d[k]) begin errors++; $display("FAIL scan_dist%0d: got %0d expected %0d", k, got_d, exp_d[k]); end
            if (k == 2) run = 1'b0;
        end
        wait_for(3, n);
        checks++; if (dist_out !== 24'h280F5A) begin errors++; $display("FAIL scan_dist_all: got %h expected 280f5a", dist_out); end
        checks++; if (near !== 3'b010) begin errors++; $display("FAIL scan_near: got %b expected 010", near); end
        checks++; if (timeout !== 3'b000) begin errors++; $display("FAIL scan_timeout: got %b expected 000", timeout); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL scan_sel_wrap: got %0d expected 0", sel); end
    endtask

    task automatic test_timeout();
        int n;
        mode[1] = 1;
        distance_in = {8'd40, 8'd15, 8'd7};
        run = 1'b1;
        wait_for(0, n);
        checks++; if (enable !== 3'b001) begin errors++; $display("FAIL to_enable0: got %b expected 001", enable); end
        wait_for(2, n);
        checks++; if (dist_out[7:0] !== 8'd7) begin errors++; $display("FAIL to_dist0: got %0d expected 7", dist_out[7:0]); end
        wait_for(0, n);
        checks++; if (enable !== 3'b010) begin errors++; $display("FAIL to_enable1: got %b expected 010", enable); end
        wait_for(1, n);
        wait_for(2, n);
        checks++; if (n != 200) begin errors++; $display("FAIL to_latency: got %0d cycles expected 200", n); end
        checks++; if (dist_valid !== 3'b010) begin errors++; $display("FAIL to_valid: got %b expected 010", dist_valid); end
        checks++; if (dist_out[15:8] !== 8'hFF) begin errors++; $display("FAIL to_dist1: got %h expected ff", dist_out[15:8]); end
        checks++; if (timeout !== 3'b010) begin errors++; $display("FAIL to_flag: got %b expected 010", timeout); end
        checks++; if (near !== 3'b001) begin errors++; $display("FAIL to_near: got %b expected 001", near); end
        wait_for(0, n);
        checks++; if (enable !== 3'b100) begin errors++; $display("FAIL to_continue: got %b expected 100", enable); end
        wait_for(2, n);
        run = 1'b0;
        wait_for(3, n);
        checks++; if (dist_out[23:16] !== 8'd40) begin errors++; $display("FAIL to_dist2: got %0d expected 40", dist_out[23:16]); end
        mode[1] = 0;
    endtask

    task automatic test_stuck_high();
        int n;
        logic [2:0] exp_oh;
        mode[0] = 2;
        repeat (5) @(negedge clk);
        run = 1'b1;
        wait_for(0, n);
        checks++; if (enable !== 3'b001) begin errors++; $display("FAIL stuck_enable: got %b expected 001", enable); end
        wait_for(1, n);
        wait_for(2, n);
        checks++; if (n != 200) begin errors++; $display("FAIL stuck_latency: got %0d cycles expected 200", n); end
        checks++; if (dist_out[7:0] !== 8'hFF) begin errors++; $display("FAIL stuck_dist: got %h expected ff", dist_out[7:0]); end
        checks++; if (timeout !== 3'b011) begin errors++; $display("FAIL stuck_flag: got %b expected 011", timeout); end
        checks++; if (near !== 3'b000) begin errors++; $display("FAIL stuck_near: got %b expected 000", near); end
        mode[0] = 0;
        for (int k = 1; k <= 3; k++) begin
            exp_oh = 3'b001 << (k % 3);
            wait_for(0, n);
            checks++; if (enable !== exp_oh) begin errors++; $display("FAIL stuck_next%0d: got %b expected %b", k, enable, exp_oh); end
            wait_for(2, n);
        end
        run = 1'b0;
        checks++; if (dist_out[7:0] !== 8'd7) begin errors++; $display("FAIL stuck_recover_dist: got %0d expected 7", dist_out[7:0]); end
        checks++; if (timeout !== 3'b000) begin errors++; $display("FAIL stuck_recover_flag: got %b expected 000", timeout); end
        checks++; if (near !== 3'b011) begin errors++; $display("FAIL stuck_recover_near: got %b expected 011", near); end
        wait_for(3, n);
    endtask

    task automatic test_run_deassert();
        int n;
        int pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        distance_in = {8'd40, 8'd15, 8'd12};
        run = 1'b1;
        wait_for(0, n);
        checks++; if (enable !== 3'b001) begin errors++; $display("FAIL rd_enable: got %b expected 001", enable); end
        wait_for(1, n);
        repeat (50) @(negedge clk);
        run = 1'b0;
        wait_for(2, n);
        checks++; if (dist_valid !== 3'b001) begin errors++; $display("FAIL rd_valid: got %b expected 001", dist_valid); end
        checks++; if (dist_out[7:0] !== 8'd12) begin errors++; $display("FAIL rd_dist: got %0d expected 12", dist_out[7:0]); end
        checks++; if (near !== 3'b001) begin errors++; $display("FAIL rd_near: got %b expected 001", near); end
        wait_for(3, n);
        checks++; if (n != 20) begin errors++; $display("FAIL rd_guard: got %0d cycles expected 20", n); end
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL rd_sel: got %0d expected 1", sel); end
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (enable !== 3'b000) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rd_no_enable: got %0d enabled cycles expected 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_fire();
        int n;
        run = 1'b1;
        wait_for(0, n);
        checks++; if (enable !== 3'b010) begin errors++; $display("FAIL rf_resume: got %b expected 010", enable); end
        wait_for(2, n);
        wait_for(0, n);
        checks++; if (enable !== 3'b100) begin errors++; $display("FAIL rf_enable2: got %b expected 100", enable); end
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (enable !== 3'b000) begin errors++; $display("FAIL rf_enable: got %b expected 000", enable); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rf_sel: got %0d expected 0", sel); end
        checks++; if (dist_out !== 24'hFFFFFF) begin errors++; $display("FAIL rf_dist: got %h expected ffffff", dist_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rf_busy: got %b expected 0", busy); end
        checks++; if (near !== 3'b000) begin errors++; $display("FAIL rf_near: got %b expected 000", near); end
        repeat (5) @(negedge clk);
        checks++; if (enable !== 3'b000) begin errors++; $display("FAIL rf_stays_idle: got %b expected 000", enable); end
    endtask

    task automatic test_exclusivity();
        int n;
        logic [2:0] exp_oh;
        noise_en = 1'b1;
        distance_in = {8'd25, 8'd19, 8'd3};
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_oh = 3'b001 << k;
            wait_for(0, n);
            checks++; if (enable !== exp_oh) begin errors++; $display("FAIL ex_enable%0d: got %b expected %b", k, enable, exp_oh); end
            wait_for(1, n);
            wait_for(2, n);
            checks++; if (n != 88) begin errors++; $display("FAIL ex_latency%0d: got %0d cycles expected 88", k, n); end
            checks++; if (dist_valid !== exp_oh) begin errors++; $display("FAIL ex_valid%0d: got %b expected %b", k, dist_valid, exp_oh); end
            if (k == 2) run = 1'b0;
        end
        wait_for(3, n);
        checks++; if (dist_out !== 24'h191303) begin errors++; $display("FAIL ex_dist: got %h expected 191303", dist_out); end
        checks++; if (near !== 3'b011) begin errors++; $display("FAIL ex_near: got %b expected 011", near); end
        checks++; if (timeout !== 3'b000) begin errors++; $display("FAIL ex_timeout: got %b expected 000", timeout); end
        noise_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        distance_in = '0;
        test_reset();
        test_normal_scan();
        test_timeout();
        test_stuck_high();
        test_run_deassert();
        test_reset_mid_fire();
        test_exclusivity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
